down_counter: RTL and testbench

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/down_counter.sv | 91 +++++++++
 tb/tb_down_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// Loadable down counter with configurable end value and step, valid/ready load handshake.
// Define DOWN_COUNTER_AUTORELOAD_EN to reload the start value on terminal count instead of stopping.
module down_counter #(
  parameter int Bits = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  input  logic            abort_i,
  input  logic            load_valid_i,
  output logic            load_ready_o,
  input  logic [Bits-1:0] start_val_i,
  input  logic [Bits-1:0] end_val_i,
  input  logic [Bits-1:0] count_by_i,
  output logic [Bits-1:0] count_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [Bits-1:0]   count_q;
  logic [Bits-1:0]   start_q;
  logic [Bits-1:0]   end_q;
  logic [Bits-1:0]   step_q;
  logic              done_q;
  logic              err_q;

  // Running count only ever uses the captured copies, so the config ports are free once loaded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      count_q <= '0;
      start_q <= '0;
      end_q   <= '0;
      step_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (load_valid_i) begin
            if (end_val_i <= start_val_i) begin
              start_q <= start_val_i;
              end_q   <= end_val_i;
              step_q  <= (count_by_i == '0) ? Bits'(1) : count_by_i;
              count_q <= start_val_i;
              state   <= RUN;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort_i) begin
            state <= IDLE;
          end else if (en_i) begin
            if (count_q == end_q) begin
              done_q <= 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
              count_q <= start_q;
`else
              state <= IDLE;
`endif
            end else if ((count_q - end_q) >= step_q) begin
              count_q <= count_q - step_q;
            end else begin
              // Remaining distance is shorter than one step: land exactly on the end value.
              count_q <= end_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign count_o      = count_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign busy_o       = (state == RUN);
  assign load_ready_o = (state == IDLE);

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: directed scenarios plus randomized traffic against a reference model.
// Honours DOWN_COUNTER_AUTORELOAD_EN in the same way as the design.
module tb_down_counter;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         en_i;
  logic         abort_i;
  logic         load_valid_i;
  logic         load_ready_o;
  logic [W-1:0] start_val_i;
  logic [W-1:0] end_val_i;
  logic [W-1:0] count_by_i;
  logic [W-1:0] count_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed as "is a count active" plus plain integers.
  bit           m_run;
  logic [W-1:0] m_cnt, m_start, m_end, m_step;
  bit           m_done, m_err;

  down_counter #(.Bits(W)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (en_i),
    .abort_i      (abort_i),
    .load_valid_i (load_valid_i),
    .load_ready_o (load_ready_o),
    .start_val_i  (start_val_i),
    .end_val_i    (end_val_i),
    .count_by_i   (count_by_i),
    .count_o      (count_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    m_run = 0; m_cnt = '0; m_start = '0; m_end = '0; m_step = '0;
    m_done = 0; m_err = 0;
  endtask

  task automatic model_edge(input logic en, input logic abort, input logic lv,
                            input logic [W-1:0] s, input logic [W-1:0] e, input logic [W-1:0] b);
    int next_val;
    m_done = 0;
    m_err  = 0;
    if (!m_run) begin
      if (lv) begin
        if (int'(e) <= int'(s)) begin
          m_start = s; m_end = e; m_cnt = s;
          m_step  = (b == 0) ? W'(1) : b;
          m_run   = 1;
        end else begin
          m_err = 1;
        end
      end
    end else if (abort) begin
      m_run = 0;
    end else if (en) begin
      if (m_cnt == m_end) begin
        m_done = 1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        m_cnt = m_start;
`else
        m_run = 0;
`endif
      end else begin
        next_val = int'(m_cnt) - int'(m_step);
        m_cnt = (next_val < int'(m_end)) ? m_end : W'(next_val);
      end
    end
  endtask

  task automatic check_val(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  task automatic check_output(input string tag);
    check_val({tag, ".count"}, int'(count_o), int'(m_cnt));
    check_val({tag, ".busy"},  int'(busy_o),  int'(m_run));
    check_val({tag, ".ready"}, int'(load_ready_o), int'(!m_run));
    check_val({tag, ".done"},  int'(done_o),  int'(m_done));
    check_val({tag, ".err"},   int'(err_o),   int'(m_err));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, and check 1ns later.
  task automatic apply_stimulus(input string tag, input logic en, input logic abort, input logic lv,
                                input logic [W-1:0] s, input logic [W-1:0] e, input logic [W-1:0] b);
    en_i = en; abort_i = abort; load_valid_i = lv;
    start_val_i = s; end_val_i = e; count_by_i = b;
    @(posedge clk_i);
    model_edge(en, abort, lv, s, e, b);
    #1;
    check_output(tag);
  endtask

  initial begin
    rst_i = 1'b1; en_i = 0; abort_i = 0; load_valid_i = 0;
    start_val_i = '0; end_val_i = '0; count_by_i = '0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_output("reset");
    rst_i = 1'b0;

    // Load on the very first edge after reset release, then count 14,11,8,5,2.
    apply_stimulus("load14", 1, 0, 1, 8'd14, 8'd2, 8'd3);
    check_val("load14.const", int'(count_o), 14);
    for (int i = 0; i < 4; i++) apply_stimulus("run14", 1, 0, 0, 8'd0, 8'd0, 8'd0);
    check_val("run14.end_const", int'(count_o), 2);
    apply_stimulus("term14", 1, 0, 0, 8'd0, 8'd0, 8'd0);
    check_val("term14.done_const", int'(done_o), 1);
    apply_stimulus("post14", 0, 1, 0, 8'd0, 8'd0, 8'd0);

    // Saturating last step: 10,6,2,0 then terminal.
    apply_stimulus("load10", 1, 0, 1, 8'd10, 8'd0, 8'd4);
    for (int i = 0; i < 3; i++) apply_stimulus("sat", 1, 0, 0, 8'd0, 8'd0, 8'd0);
    check_val("sat.zero_const", int'(count_o), 0);
    apply_stimulus("sat_term", 1, 0, 0, 8'd0, 8'd0, 8'd0);
    apply_stimulus("sat_abort", 0, 1, 0, 8'd0, 8'd0, 8'd0);

    // Rejected load, then a zero-step load that counts by one.
    apply_stimulus("badload", 1, 0, 1, 8'd3, 8'd9, 8'd1);
    check_val("badload.err_const", int'(err_o), 1);
    apply_stimulus("badload_after", 1, 0, 0, 8'd0, 8'd0, 8'd0);
    apply_stimulus("step0", 1, 0, 1, 8'd2, 8'd0, 8'd0);
    for (int i = 0; i < 3; i++) apply_stimulus("step0_run", 1, 0, 0, 8'd0, 8'd0, 8'd0);
    apply_stimulus("step0_abort", 0, 1, 0, 8'd0, 8'd0, 8'd0);

    // Hold with enable low at 6, ignored load while running, then resume.
    apply_stimulus("hold_load", 0, 0, 1, 8'd8, 8'd0, 8'd1);
    for (int i = 0; i < 2; i++) apply_stimulus("hold_run", 1, 0, 0, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 5; i++) apply_stimulus("hold_en0", 0, 0, 0, 8'd0, 8'd0, 8'd0);
    check_val("hold.six_const", int'(count_o), 6);
    apply_stimulus("run_ignore_load", 0, 0, 1, 8'd200, 8'd100, 8'd7);
    for (int i = 0; i < 2; i++) apply_stimulus("resume", 1, 0, 0, 8'd0, 8'd0, 8'd0);
    check_val("resume.four_const", int'(count_o), 4);
    apply_stimulus("resume_abort", 1, 1, 0, 8'd0, 8'd0, 8'd0);

    // Abort on the terminal edge beats done; abort in IDLE does not block a load.
    apply_stimulus("abt_load", 1, 0, 1, 8'd1, 8'd0, 8'd1);
    apply_stimulus("abt_step", 1, 0, 0, 8'd0, 8'd0, 8'd0);
    apply_stimulus("abt_term", 1, 1, 0, 8'd0, 8'd0, 8'd0);
    apply_stimulus("idle_abort_load", 0, 1, 1, 8'd5, 8'd5, 8'd0);
    apply_stimulus("eq_term", 1, 0, 0, 8'd0, 8'd0, 8'd0);
    apply_stimulus("eq_abort", 0, 1, 0, 8'd0, 8'd0, 8'd0);

    // Asynchronous reset while counting at 7.
    apply_stimulus("rst_load", 1, 0, 1, 8'd13, 8'd1, 8'd3);
    for (int i = 0; i < 2; i++) apply_stimulus("rst_run", 1, 0, 0, 8'd0, 8'd0, 8'd0);
    check_val("rst_run.seven_const", int'(count_o), 7);
    #2 rst_i = 1'b1;
    model_reset();
    #1;
    check_output("rst_async");
    @(posedge clk_i);
    #1;
    check_output("rst_held");
    rst_i = 1'b0;
    apply_stimulus("rst_first_load", 1, 0, 1, 8'd9, 8'd3, 8'd2);
    apply_stimulus("rst_first_run", 1, 0, 0, 8'd0, 8'd0, 8'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] rs, re, rb;
      rs = W'($urandom_range(0, 60));
      re = W'($urandom_range(0, 40));
      rb = W'($urandom_range(0, 9));
      apply_stimulus("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
                     ($urandom_range(0, 2) == 0), rs, re, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
